// File: rtl/fifo_distram32.sv
// 32-entry first-word-fall-through FIFO over a distributed RAM with an asynchronous read port.
// The producer writes through port A. The consumer sees the head entry combinationally on port B.

module distram32d #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [4:0]       i_a_addr,
    input  logic [WIDTH-1:0] i_a_wrdata,
    input  logic [WIDTH-1:0] i_a_wren,
    input  logic [4:0]       i_b_addr,
    output logic [WIDTH-1:0] o_b_rddata
);
    logic [WIDTH-1:0] r_mem [0:31];

    // Each bit has its own write enable, so a partial mask merges with the old word.
    always_ff @(posedge clk) begin
        if (|i_a_wren) begin
            r_mem[i_a_addr] <= (r_mem[i_a_addr] & ~i_a_wren) | (i_a_wrdata & i_a_wren);
        end
    end

    assign o_b_rddata = r_mem[i_b_addr];
endmodule

module fifo_distram32 #(
    parameter int WIDTH       = 8,
    parameter int AFULL_LEVEL = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic             almost_full,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_en,
    output logic             empty,
    output logic [5:0]       count,
    output logic             overflow,
    output logic             underflow
);
    logic [4:0]       r_wr_ptr;
    logic [4:0]       r_rd_ptr;
    logic [5:0]       r_cnt;
    logic             r_ovf;
    logic             r_udf;
    logic             w_full;
    logic             w_empty;
    logic             w_do_wr;
    logic             w_do_rd;
    logic             w_ram_we;
    logic [WIDTH-1:0] w_a_wren;
    logic [WIDTH-1:0] w_b_rddata;

    assign w_full  = (r_cnt == 6'd32);
    assign w_empty = (r_cnt == 6'd0);

    // Handshake: wr_en and rd_en are requests that the FIFO accepts in the same cycle.
    // A write is accepted when the FIFO is not full, and a read when it is not empty.
    // Both checks use the count registered at the start of the cycle. A refused
    // request only sets its sticky flag.
    assign w_do_wr  = wr_en & ~w_full;
    assign w_do_rd  = rd_en & ~w_empty;
    assign w_ram_we = w_do_wr & ~flush & ~reset;
    assign w_a_wren = {WIDTH{w_ram_we}};

    distram32d #(.WIDTH(WIDTH)) u_ram (
        .clk        (clk),
        .i_a_addr   (r_wr_ptr),
        .i_a_wrdata (wr_data),
        .i_a_wren   (w_a_wren),
        .i_b_addr   (r_rd_ptr),
        .o_b_rddata (w_b_rddata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 5'd0;
            r_rd_ptr <= 5'd0;
            r_cnt    <= 6'd0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= 5'd0;
            r_rd_ptr <= 5'd0;
            r_cnt    <= 6'd0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 5'd1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 5'd1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_cnt <= r_cnt + 6'd1;
            end else if (w_do_rd && !w_do_wr) begin
                r_cnt <= r_cnt - 6'd1;
            end
            if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_cnt >= 6'(AFULL_LEVEL));
    assign count       = r_cnt;
    assign rd_data     = w_b_rddata;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;
endmodule
